// File: rtl/pc11_pkg.sv
// pc11_pkg: shared constants for the PC11 paper-tape register block.
//   Register byte offsets from BASE_ADDR, status bit positions, and the
//   default bus address and interrupt vectors.
package pc11_pkg;

    localparam logic [15:0] PC11_BASE_DEF = 16'o177550;
    localparam logic [7:0]  PR_VECTOR_DEF = 8'o070;
    localparam logic [7:0]  PP_VECTOR_DEF = 8'o074;

    // Byte offsets of the four word registers
    localparam logic [2:0] OFF_PRS = 3'd0;
    localparam logic [2:0] OFF_PRB = 3'd2;
    localparam logic [2:0] OFF_PPS = 3'd4;
    localparam logic [2:0] OFF_PPB = 3'd6;

    // Status/control bit positions
    localparam int BIT_ERR   = 15;
    localparam int BIT_BUSY  = 11;
    localparam int BIT_DONE  = 7;
    localparam int BIT_READY = 7;
    localparam int BIT_IE    = 6;
    localparam int BIT_GO    = 0;

    typedef enum logic [1:0] {
        REG_PRS = OFF_PRS[2:1],
        REG_PRB = OFF_PRB[2:1],
        REG_PPS = OFF_PPS[2:1],
        REG_PPB = OFF_PPB[2:1]
    } reg_sel_e;

endpackage

// File: rtl/pc11_irq_req.sv
// pc11_irq_req: one interrupt request flop.
//   Sets on a rising edge of i_cond, clears on i_ack or when i_cond drops.
//   A rising edge in the same cycle as i_ack keeps the request set.
// Ports:
//   i_clk, i_reset_n  clock, async active-low reset
//   i_cond            IE & flag for this channel
//   i_ack             acknowledge aimed at this channel
//   o_req             registered request
module pc11_irq_req (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_cond,
    input  logic i_ack,
    output logic o_req
);

    logic r_cond_d;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cond_d <= 1'b0;
            o_req    <= 1'b0;
        end else begin
            r_cond_d <= i_cond;
            if (i_cond && !r_cond_d)
                o_req <= 1'b1;
            else if (i_ack || !i_cond)
                o_req <= 1'b0;
        end
    end

endmodule

// File: rtl/pc11_regs.sv
// pc11_regs: PDP-11 PC11 paper-tape reader/punch registers (PRS/PRB/PPS/PPB)
//   and BR4 interrupt requester between the I/O-page decode and the tape
//   emulator. CPU accesses become one-cycle read/punch/clear-done commands.
// Ports:
//   i_clk, i_reset_n            clock, async active-low reset
//   i_addr, i_rd, i_wr, i_byte  bus access (i_addr[0] picks the byte)
//   i_wdata / o_rdata, o_hit    write data / registered read data and hit
//   o_irq, o_vector, i_iack     interrupt request, vector, acknowledge
//   o_tape_read/punch/clear_done one-cycle command pulses to the tape engine
//   o_tape_punch_data           punch byte, held until the next PPB write
//   i_tape_*                    tape engine status and reader byte
//   i_sd_error                  nonzero blocks command issue
module pc11_regs
    import pc11_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = PC11_BASE_DEF,
    parameter logic [7:0]  PR_VECTOR = PR_VECTOR_DEF,
    parameter logic [7:0]  PP_VECTOR = PP_VECTOR_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_addr,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic        i_byte,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_hit,
    output logic        o_irq,
    output logic [7:0]  o_vector,
    input  logic        i_iack,
    output logic        o_tape_read,
    output logic        o_tape_punch,
    output logic        o_tape_clear_done,
    output logic [7:0]  o_tape_punch_data,
    input  logic        i_tape_read_busy,
    input  logic        i_tape_read_done,
    input  logic        i_tape_punch_ready,
    input  logic [7:0]  i_tape_read_data,
    input  logic [3:0]  i_sd_error
);

    logic r_rd_pend, r_rd_inflight, r_pp_pend, r_pp_inflight;
    logic r_pr_ie, r_pp_ie;

    logic       w_hit, w_lo_wr, w_err, w_pp_ready;
    logic       w_rd_issue, w_pp_issue;
    logic       w_prs_wr, w_pps_wr, w_ppb_wr;
    logic       w_pr_req, w_pp_req, w_pr_ack, w_pp_ack;
    reg_sel_e   w_sel;
    logic [15:0] w_prs, w_pps, w_rd_mux;
    logic       w_unused;

    assign w_unused = ^i_wdata[15:8];

    assign w_hit  = (i_addr[15:3] == BASE_ADDR[15:3]);
    assign w_sel  = reg_sel_e'(i_addr[2:1]);
    // High-byte writes never reach IE/GO/punch data, so they are dropped.
    assign w_lo_wr  = i_wr & w_hit & ~(i_byte & i_addr[0]);
    assign w_prs_wr = w_lo_wr & (w_sel == REG_PRS);
    assign w_pps_wr = w_lo_wr & (w_sel == REG_PPS);
    assign w_ppb_wr = w_lo_wr & (w_sel == REG_PPB);

    assign w_err      = |i_sd_error;
    assign w_pp_ready = i_tape_punch_ready & ~r_pp_pend & ~r_pp_inflight;

    // Reader wins a same-cycle conflict; the punch goes out next cycle.
    assign w_rd_issue = r_rd_pend & ~i_tape_read_busy & ~r_rd_inflight & ~w_err;
    assign w_pp_issue = r_pp_pend & i_tape_punch_ready & ~r_pp_inflight & ~w_err
                        & ~w_rd_issue;

    always_comb begin
        w_prs = '0;
        w_prs[BIT_ERR]  = w_err;
        w_prs[BIT_BUSY] = i_tape_read_busy | r_rd_pend;
        w_prs[BIT_DONE] = i_tape_read_done;
        w_prs[BIT_IE]   = r_pr_ie;
        w_pps = '0;
        w_pps[BIT_ERR]   = w_err;
        w_pps[BIT_READY] = w_pp_ready;
        w_pps[BIT_IE]    = r_pp_ie;
        unique case (w_sel)
            REG_PRS: w_rd_mux = w_prs;
            REG_PRB: w_rd_mux = {8'h00, i_tape_read_data};
            REG_PPS: w_rd_mux = w_pps;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rdata           <= '0;
            o_hit             <= 1'b0;
            o_tape_read       <= 1'b0;
            o_tape_punch      <= 1'b0;
            o_tape_clear_done <= 1'b0;
            o_tape_punch_data <= '0;
            r_rd_pend         <= 1'b0;
            r_rd_inflight     <= 1'b0;
            r_pp_pend         <= 1'b0;
            r_pp_inflight     <= 1'b0;
            r_pr_ie           <= 1'b0;
            r_pp_ie           <= 1'b0;
        end else begin
            if (i_rd)
                o_rdata <= w_hit ? w_rd_mux : 16'h0000;
            if (i_rd || i_wr)
                o_hit <= w_hit;
            o_tape_clear_done <= i_rd & w_hit & (w_sel == REG_PRB);
            o_tape_read       <= w_rd_issue;
            o_tape_punch      <= w_pp_issue;

            // Inflight covers the gap until the engine reflects the command.
            if (w_rd_issue)            r_rd_inflight <= 1'b1;
            else if (i_tape_read_busy) r_rd_inflight <= 1'b0;
            if (w_pp_issue)              r_pp_inflight <= 1'b1;
            else if (!i_tape_punch_ready) r_pp_inflight <= 1'b0;

            // A new request arriving with an issue re-arms the pend flag.
            if (w_prs_wr && i_wdata[BIT_GO]) r_rd_pend <= 1'b1;
            else if (w_rd_issue)             r_rd_pend <= 1'b0;
            if (w_ppb_wr)        r_pp_pend <= 1'b1;
            else if (w_pp_issue) r_pp_pend <= 1'b0;

            if (w_prs_wr) r_pr_ie <= i_wdata[BIT_IE];
            if (w_pps_wr) r_pp_ie <= i_wdata[BIT_IE];
            if (w_ppb_wr) o_tape_punch_data <= i_wdata[7:0];
        end
    end

    // Only the request currently presented is acknowledged.
    assign w_pr_ack = i_iack & w_pr_req;
    assign w_pp_ack = i_iack & ~w_pr_req & w_pp_req;

    pc11_irq_req u_pr_irq (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_cond    (r_pr_ie & i_tape_read_done),
        .i_ack     (w_pr_ack),
        .o_req     (w_pr_req)
    );

    pc11_irq_req u_pp_irq (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_cond    (r_pp_ie & w_pp_ready),
        .i_ack     (w_pp_ack),
        .o_req     (w_pp_req)
    );

    assign o_irq = w_pr_req | w_pp_req;
    // Vector reads 0 with nothing pending so every output is 0 out of reset.
    assign o_vector = w_pr_req ? PR_VECTOR : (w_pp_req ? PP_VECTOR : 8'h00);

endmodule
